// File: rtl/fft8_pkg.sv
// fft8_pkg: shared constants, record types and butterfly schedule for the 8-point radix-2 DIT FFT
// Contents: FP16 width, point count, stage/butterfly counts, ROM latency, sequencer state type,
// bf_rec_t record handed to the butterfly datapath, and bf_sched() mapping a butterfly number
// (0..11, issue order) to {stage, addr_a, addr_b, twiddle exponent k}.
package fft8_pkg;

    localparam int FP16_W       = 16;
    localparam int N            = 8;
    localparam int LOG2N        = $clog2(N);
    localparam int NSTAGE       = 3;
    localparam int BF_PER_STAGE = 4;
    localparam int NBF          = NSTAGE * BF_PER_STAGE;
    localparam int ROM_LAT      = 2;
    localparam logic [FP16_W-1:0] FP16_SIGN = 16'h8000;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

    typedef struct packed {
        logic [1:0]        stage;
        logic [LOG2N-1:0]  addr_a;
        logic [LOG2N-1:0]  addr_b;
        logic [FP16_W-1:0] wreal;
        logic [FP16_W-1:0] wimag;
    } bf_rec_t;

    // Addressing metadata that rides alongside an outstanding ROM read.
    typedef struct packed {
        logic             v;
        logic [1:0]       stage;
        logic [LOG2N-1:0] addr_a;
        logic [LOG2N-1:0] addr_b;
    } meta_t;

    typedef struct packed {
        logic [1:0]       stage;
        logic [LOG2N-1:0] addr_a;
        logic [LOG2N-1:0] addr_b;
        logic [LOG2N-1:0] k;
    } sched_t;

    // n[3:2] is the stage, n[1:0] the butterfly j within it. The upper-leg address
    // inserts a zero bit at position s of j (group*2*span + j mod span), the lower
    // leg sets that bit, and k = (j mod span) << (2-s).
    function automatic sched_t bf_sched(input logic [3:0] n);
        sched_t r;
        r.stage  = n[3:2];
        r.addr_a = n[3] ? {1'b0, n[1:0]} : n[2] ? {n[1], 1'b0, n[0]} : {n[1:0], 1'b0};
        r.addr_b = r.addr_a | (3'd1 << n[3:2]);
        r.k      = n[3] ? {1'b0, n[1:0]} : n[2] ? {1'b0, n[0], 1'b0} : 3'd0;
        return r;
    endfunction

endpackage

// File: rtl/twseq_fifo.sv
// twseq_fifo: synchronous FIFO of bf_rec_t records with occupancy count
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, empties the FIFO
//   push_i   in   write data_i this cycle
//   data_i   in   record to write
//   pop_i    in   remove head this cycle (caller only pops when valid_o)
//   data_o   out  head record, read straight from the storage registers
//   valid_o  out  FIFO non-empty
//   count_o  out  number of stored records
// Push and pop may coincide at any occupancy; the caller guarantees no push when full.
module twseq_fifo
    import fft8_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  bf_rec_t       data_i,
    input  logic          pop_i,
    output bf_rec_t       data_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    bf_rec_t       mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q == AW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
            end
            if (pop_i)
                rd_q <= rd_q == AW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign valid_o = count_q != '0;
    assign count_o = count_q;

endmodule

// File: rtl/twiddle_sequencer.sv
// twiddle_sequencer: 8-point FFT butterfly scheduler and twiddle ROM fetch initiator
// Ports:
//   clk, rst             clock (rising edge) and synchronous active-high reset
//   inverse              (only with TWSEQ_INVERSE_EN) conjugate twiddles for this run, sampled with start
//   start                begin a 12-butterfly schedule; ignored while busy or in the done cycle
//   busy, done           run in progress / one-cycle pulse after the last handshake
//   rom_index, rom_en    twiddle exponent and read enable to the 2-cycle-latency ROM
//   rom_wreal, rom_wimag FP16 twiddle returned by the ROM
//   bf_valid, bf_ready   record handshake to the butterfly datapath
//   bf_stage, bf_addr_a, bf_addr_b, bf_wreal, bf_wimag  record fields
// Macro TWSEQ_INVERSE_EN adds the inverse port and conjugates bf_wimag when it is set.
module twiddle_sequencer
    import fft8_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef TWSEQ_INVERSE_EN
    input  logic              inverse,
`endif
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [LOG2N-1:0]  rom_index,
    output logic              rom_en,
    input  logic [FP16_W-1:0] rom_wreal,
    input  logic [FP16_W-1:0] rom_wimag,
    output logic              bf_valid,
    input  logic              bf_ready,
    output logic [1:0]        bf_stage,
    output logic [LOG2N-1:0]  bf_addr_a,
    output logic [LOG2N-1:0]  bf_addr_b,
    output logic [FP16_W-1:0] bf_wreal,
    output logic [FP16_W-1:0] bf_wimag
);

    localparam int CW = $clog2(DEPTH + 1);
    // One stage for the issue register plus one per ROM latency cycle.
    localparam int SR = ROM_LAT + 1;

    state_t           state_q;
    logic [3:0]       iss_q, hs_q;
    logic [LOG2N-1:0] idx_q;
    logic             done_q;
    meta_t            sr_q [SR];
`ifdef TWSEQ_INVERSE_EN
    logic             inv_q;
`endif

    logic              accept, issue, push, pop, head_v;
    logic [1:0]        inflight;
    logic [CW-1:0]     fifo_cnt;
    logic [FP16_W-1:0] wimag_d;
    sched_t            sched_d;
    bf_rec_t           push_rec, head, out;

    // Credits cover every record already in flight or stored; a pop this cycle
    // frees its slot immediately so a full pipeline sustains one issue per cycle.
    always_comb begin
        inflight = 2'(sr_q[0].v) + 2'(sr_q[1].v) + 2'(sr_q[2].v);
        pop      = head_v & bf_ready;
        push     = sr_q[SR-1].v;
        accept   = state_q == ST_IDLE && start && !done_q;
        issue    = accept || (state_q == ST_ISSUE &&
                   int'(inflight) + int'(fifo_cnt) - int'(pop) < DEPTH);
        sched_d  = bf_sched(accept ? 4'd0 : iss_q);
    end

`ifdef TWSEQ_INVERSE_EN
    // Conjugate by flipping the sign; a zero imaginary part stays +0.
    assign wimag_d = !inv_q ? rom_wimag : rom_wimag[FP16_W-2:0] == '0 ? '0 : rom_wimag ^ FP16_SIGN;
`else
    assign wimag_d = rom_wimag;
`endif

    assign push_rec = '{stage: sr_q[SR-1].stage, addr_a: sr_q[SR-1].addr_a,
                        addr_b: sr_q[SR-1].addr_b, wreal: rom_wreal, wimag: wimag_d};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            iss_q   <= '0;
            hs_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < SR; i++)
                sr_q[i] <= '0;
`ifdef TWSEQ_INVERSE_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            sr_q[0] <= '{v: issue, stage: sched_d.stage, addr_a: sched_d.addr_a, addr_b: sched_d.addr_b};
            for (int i = 1; i < SR; i++)
                sr_q[i] <= sr_q[i-1];
            if (issue) begin
                idx_q <= sched_d.k;
                iss_q <= iss_q + 4'd1;
            end
            if (pop)
                hs_q <= hs_q + 4'd1;
            if (accept) begin
                state_q <= ST_ISSUE;
                iss_q   <= 4'd1;
                hs_q    <= '0;
`ifdef TWSEQ_INVERSE_EN
                inv_q   <= inverse;
`endif
            end else if (state_q == ST_ISSUE && issue && iss_q == 4'(NBF - 1)) begin
                state_q <= ST_DRAIN;
            end else if (state_q == ST_DRAIN && pop && hs_q == 4'(NBF - 1)) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
            end
        end
    end

    twseq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_rec),
        .pop_i   (pop),
        .data_o  (head),
        .valid_o (head_v),
        .count_o (fifo_cnt)
    );

    // Idle FIFO storage is never reset, so the record bus is forced to zero when empty.
    assign out       = head_v ? head : '0;
    assign bf_valid  = head_v;
    assign bf_stage  = out.stage;
    assign bf_addr_a = out.addr_a;
    assign bf_addr_b = out.addr_b;
    assign bf_wreal  = out.wreal;
    assign bf_wimag  = out.wimag;
    assign busy      = state_q != ST_IDLE;
    assign done      = done_q;
    assign rom_index = idx_q;
    assign rom_en    = state_q == ST_ISSUE || (state_q == ST_DRAIN && inflight != 2'd0);

endmodule

// File: tb/tb_twiddle_sequencer.sv
// tb_twiddle_sequencer: scoreboard bench for twiddle_sequencer with a behavioural 2-cycle twiddle ROM
module tb_twiddle_sequencer;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, inverse = 1'b0;
    logic        busy, done, rom_en, bf_valid, bf_ready;
    logic [2:0]  rom_index, bf_addr_a, bf_addr_b;
    logic [1:0]  bf_stage;
    logic [15:0] rom_wreal, rom_wimag, bf_wreal, bf_wimag;

    int checks = 0, errors = 0, done_cnt = 0, hs_cnt = 0, mode = 0;

    typedef struct packed {
        logic [1:0]  stage;
        logic [2:0]  a, b;
        logic [15:0] wr, wi;
    } exp_t;
    exp_t exp_q[$];

    twiddle_sequencer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TWSEQ_INVERSE_EN
        .inverse   (inverse),
`endif
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rom_index (rom_index),
        .rom_en    (rom_en),
        .rom_wreal (rom_wreal),
        .rom_wimag (rom_wimag),
        .bf_valid  (bf_valid),
        .bf_ready  (bf_ready),
        .bf_stage  (bf_stage),
        .bf_addr_a (bf_addr_a),
        .bf_addr_b (bf_addr_b),
        .bf_wreal  (bf_wreal),
        .bf_wimag  (bf_wimag)
    );

    always #5 clk = ~clk;

    // Behavioural twiddle ROM W8^k: latches index when enabled, drives data two edges later, Z otherwise.
    logic [15:0] wr_tab [8] = '{16'h3c00, 16'h39a8, 16'h0000, 16'hb9a8, 16'hbc00, 16'hb9a8, 16'h0000, 16'h39a8};
    logic [15:0] wi_tab [8] = '{16'h0000, 16'hb9a8, 16'hbc00, 16'hb9a8, 16'h0000, 16'h39a8, 16'h3c00, 16'h39a8};
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [2:0]  p1 = '0, p2 = '0;
    always @(posedge clk) begin
        v1 <= rom_en;
        p1 <= rom_index;
        v2 <= v1;
        p2 <= p1;
    end
    assign rom_wreal = v2 ? wr_tab[p2] : 16'hzzzz;
    assign rom_wimag = v2 ? wi_tab[p2] : 16'hzzzz;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference schedule straight from the FFT definition: span, group, j mod span.
    task automatic push_expected(input bit inv);
        logic [15:0] wr_k [4] = '{16'h3c00, 16'h39a8, 16'h0000, 16'hb9a8};
        logic [15:0] wi_k [4] = '{16'h0000, 16'hb9a8, 16'hbc00, 16'hb9a8};
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < 4; j++) begin
                int span = 1 << s;
                int a = (j / span) * 2 * span + j % span;
                int k = (j % span) * (4 >> s);
                exp_t e;
                e.stage = 2'(s);
                e.a     = 3'(a);
                e.b     = 3'(a + span);
                e.wr    = wr_k[k];
                e.wi    = (inv && wi_k[k] != 16'h0000) ? wi_k[k] ^ 16'h8000 : wi_k[k];
                exp_q.push_back(e);
            end
        end
    endtask

    // Ready pattern: 0 = always, 1 = toggling, 2 = random, 3 = held low.
    initial begin
        bf_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bf_ready = mode == 0 ? 1'b1 : mode == 1 ? ~bf_ready : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: any presented record must be the scoreboard head; it is retired on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (bf_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_record got %h %h %h expected none", bf_stage, bf_addr_a, bf_addr_b);
                end else begin
                    chk("record", 64'({bf_stage, bf_addr_a, bf_addr_b, bf_wreal, bf_wimag}), 64'(exp_q[0]));
                    if (bf_ready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_rom_index"}, 64'(rom_index), 0);
        chk({tag, "_rom_en"}, 64'(rom_en), 0);
        chk({tag, "_bf_valid"}, 64'(bf_valid), 0);
        chk({tag, "_bf_stage"}, 64'(bf_stage), 0);
        chk({tag, "_bf_addr_a"}, 64'(bf_addr_a), 0);
        chk({tag, "_bf_addr_b"}, 64'(bf_addr_b), 0);
        chk({tag, "_bf_wreal"}, 64'(bf_wreal), 0);
        chk({tag, "_bf_wimag"}, 64'(bf_wimag), 0);
    endtask

    task automatic start_run(input bit inv);
        @(negedge clk);
        start = 1'b1;
`ifdef TWSEQ_INVERSE_EN
        inverse = inv;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        push_expected(inv);
    endtask

    task automatic wait_done(input string name, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt - d0), 1);
        @(negedge clk);
        chk({name, "_drained"}, 64'(exp_q.size()), 0);
        chk({name, "_idle"}, 64'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, h0, n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        rst = 1'b0;

        // Back-to-back run with exact latency, done timing and start ignored in the done cycle.
        mode = 0;
        d0 = done_cnt;
        start_run(1'b0);
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("e0_busy", 64'(busy), 1);
                chk("e0_rom_en", 64'(rom_en), 1);
                chk("e0_rom_index", 64'(rom_index), 0);
            end
            if (c == 2) chk("latency_not_yet", 64'(bf_valid), 0);
            if (c == 3) chk("latency_valid", 64'(bf_valid), 1);
            if (c == 14) chk("done_early", 64'(done), 0);
            if (c == 15) begin
                chk("done_e15", 64'(done), 1);
                chk("busy_e15", 64'(busy), 0);
                start = 1'b1;
            end
            if (c == 16) begin
                start = 1'b0;
                chk("done_pulse_end", 64'(done), 0);
                chk("start_in_done_ignored", 64'(busy), 0);
            end
        end
        chk("run1_done_count", 64'(done_cnt - d0), 1);
        chk("run1_drained", 64'(exp_q.size()), 0);

        // Toggling ready, then random ready.
        mode = 1;
        d0 = done_cnt;
        start_run(1'b0);
        wait_done("toggle", d0);
        mode = 2;
        for (int r = 0; r < 3; r++) begin
            d0 = done_cnt;
            start_run(1'b0);
            wait_done("random", d0);
        end

        // Consumer stalled: FIFO fills, issue freezes after the fourth credit.
        mode = 3;
        d0 = done_cnt;
        start_run(1'b0);
        repeat (20) @(negedge clk);
        chk("stall_valid", 64'(bf_valid), 1);
        chk("stall_rom_index", 64'(rom_index), 0);
        chk("stall_busy", 64'(busy), 1);
        chk("stall_pending", 64'(exp_q.size()), 12);
        mode = 0;
        wait_done("stall", d0);

        // Reset after the sixth record, then a clean restart from stage 0.
        h0 = hs_cnt;
        start_run(1'b0);
        n = 0;
        while (hs_cnt - h0 < 6 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("six_records", 64'(hs_cnt - h0), 6);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        d0 = done_cnt;
        start_run(1'b0);
        wait_done("restart", d0);

        // Extra start pulses while busy are ignored.
        mode = 2;
        d0 = done_cnt;
        start_run(1'b0);
        for (int p = 0; p < 2; p++) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done("busy_start", d0);
        repeat (30) @(negedge clk);
        chk("busy_start_one_done", 64'(done_cnt - d0), 1);
        chk("busy_start_still_idle", 64'(busy), 0);

`ifdef TWSEQ_INVERSE_EN
        mode = 2;
        d0 = done_cnt;
        start_run(1'b1);
        wait_done("inverse", d0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/twiddle_sequencer.md
# twiddle_sequencer

Butterfly scheduler and twiddle fetch initiator for the 8-point radix-2 DIT FFT. On `start` it walks the 12 butterflies (3 stages × 4) in fixed order, drives the twiddle ROM's `index`/`en`, aligns the ROM's 2-cycle read latency with per-butterfly addressing metadata, and hands each {stage, addr_a, addr_b, Wreal, Wimag} record to the butterfly datapath over a valid/ready interface. It sits between the top-level FFT controller and the twiddle ROM / butterfly unit.

## Interface
- `DEPTH`, 4, output FIFO entries (1..8); ≥4 needed for one butterfly per cycle
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one FFT schedule; ignored while `busy`
- `busy`  out  1  high from accepted `start` until the `done` cycle
- `done`  out  1  one-cycle pulse after final butterfly handshake
- `rom_index`  out  3  twiddle exponent k to ROM
- `rom_en`  out  1  ROM read enable
- `rom_wreal`  in  16  FP16 twiddle real from ROM
- `rom_wimag`  in  16  FP16 twiddle imag from ROM
- `bf_valid`  out  1  record available
- `bf_ready`  in  1  butterfly accepts record
- `bf_stage`  out  2  stage 0..2
- `bf_addr_a`  out  3  upper-leg data address
- `bf_addr_b`  out  3  lower-leg data address
- `bf_wreal`  out  16  FP16 twiddle real
- `bf_wimag`  out  16  FP16 twiddle imag

## Operation
- Schedule, stage s, span=1<<s, butterfly j: a = group·2·span + (j mod span), b = a+span, k = (j mod span)·(4>>s).
- Stage 0: (0,1)(2,3)(4,5)(6,7) k=0. Stage 1: (0,2)k0 (1,3)k2 (4,6)k0 (5,7)k2. Stage 2: (0,4)k0 (1,5)k1 (2,6)k2 (3,7)k3.
- States: IDLE → ISSUE (on `start`) → DRAIN (after 12th index issued) → IDLE (after 12th handshake).
- ISSUE: one index per cycle when inflight + fifo_count < DEPTH; else hold `rom_index`, stall counter.
- Metadata {stage,a,b} travels in a 3-deep shift register matched to index→FIFO latency; ROM data and metadata pushed together.
- `rom_en` = 1 in ISSUE and DRAIN while inflight > 0; ROM outputs Z when `en`=0, so no capture ever occurs then.
- FIFO push/pop same cycle allowed at any occupancy; credit rule prevents overflow.
- Stage ordering is enforced by issue order only; the butterfly must consume in order.
- `rst` at any time: state IDLE, counters, shift register and FIFO flushed; in-flight ROM reads discarded.
- Reset values: `busy`=0, `done`=0, `rom_index`=0, `rom_en`=0, `bf_valid`=0, `bf_stage`=0, `bf_addr_a`=0, `bf_addr_b`=0, `bf_wreal`=0, `bf_wimag`=0.

## Timing
- `start` sampled edge E0 → after E0: `busy`=1, `rom_en`=1, `rom_index`=k of butterfly 0.
- ROM latches index at E1, drives data after E2; sequencer pushes FIFO at E3; `bf_valid`=1 after E3 (3-cycle latency).
- `bf_ready` held 1, DEPTH=4: 12 consecutive handshakes E4..E15; `done`=1 and `busy`=0 after E15, `done` low after E16.
- FIFO output is registered: `bf_*` stable while `bf_valid`=1 and `bf_ready`=0.
- `start` in the `done` cycle is ignored; accepted from the next cycle.

## Configuration
- `TWSEQ_INVERSE_EN`: compiled in, adds input `inverse` (1 bit, sampled with `start`, held for the run); when 1, `bf_wimag` = `rom_wimag` with bit 15 inverted (conjugate twiddle for IFFT), except 0x0000/0x8000 map to 0x0000.
- Not defined: no `inverse` port; twiddles passed unmodified.

## Structure
- Package `fft8_pkg`: FP16 width (16), N=8, LOG2N=3, stage count 3, butterflies per stage 4, FP16 sign mask 0x8000, ROM latency 2, packed typedef `bf_rec_t` {stage, addr_a, addr_b, wreal, wimag}.
- Sub-module `twseq_fifo`: synchronous FIFO of `bf_rec_t`, DEPTH entries, count output, simultaneous push/pop.
- Test bench uses a behavioural ROM with identical 2-cycle latency and Z-when-disabled output.

## Test plan
- `start` pulse, `bf_ready`=1 → 12 records in schedule order; record 5 = stage 1, a=1, b=3, W=0x0000/0xbc00; `done` after E15.
- `bf_ready` toggling 1/0 every cycle → same 12 records, none duplicated/dropped, `bf_*` stable during stalls.
- `bf_ready`=0 for 20 cycles after `start` → FIFO fills to DEPTH, `rom_index` frozen, then releases records in order.
- `rst` at record 6 → all outputs at reset values next cycle; fresh `start` restarts from stage 0 (0,1).
- `start` pulsed while `busy` → ignored, exactly 12 records, one `done`.
- With `TWSEQ_INVERSE_EN`, `inverse`=1 → stage 2 record (1,5) gives 0x39a8/0x39a8; k=0 records give 0x3c00/0x0000.
